enemy_shot: RTL and testbench



---
 rtl/enemy_shot_if.sv | 31 +++
 rtl/enemy_shot.sv | 197 +++++++++++++++++++
 tb/tb_enemy_shot.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/enemy_shot_if.sv
// Bundle of video counters, formation/ship state and shot outputs shared by
// enemy_shot and the game top level.
interface enemy_shot_if #(
   parameter int COLS = 8,
   parameter int ROWS = 3
);
   logic [9:0]           h_counter;
   logic [9:0]           v_counter;
   logic                 enable;
   logic [COLS*ROWS-1:0] alive_mask;
   logic [9:0]           grid_x0;
   logic [9:0]           grid_y0;
   logic [9:0]           posX_nave;
   logic                 shot_active;
   logic [9:0]           posX_shot;
   logic [9:0]           posY_shot;
   logic                 player_hit;
   logic [7:0]           R;
   logic [7:0]           G;
   logic [7:0]           B;

   modport master (
      output h_counter, v_counter, enable, alive_mask, grid_x0, grid_y0, posX_nave,
      input  shot_active, posX_shot, posY_shot, player_hit, R, G, B
   );

   modport slave (
      input  h_counter, v_counter, enable, alive_mask, grid_x0, grid_y0, posX_nave,
      output shot_active, posX_shot, posY_shot, player_hit, R, G, B
   );
endinterface

// File: rtl/enemy_shot.sv
// Enemy shot: picks a shooter column, drops a shot from its lowest invader,
// detects ship collision and draws the shot. ENEMY_SHOT_ACCEL_EN speeds shots up as invaders die.
module enemy_shot #(
   parameter int          COLS            = 8,
   parameter int          ROWS            = 3,
   parameter int          COL_PITCH       = 80,
   parameter int          ROW_PITCH       = 50,
   parameter int          ENEMY_W         = 40,
   parameter int          ENEMY_H         = 30,
   parameter int          SHOT_W          = 4,
   parameter int          SHOT_H          = 12,
   parameter int          SHOT_SPEED      = 4,
   parameter int          COOLDOWN_FRAMES = 30,
   parameter int          SHIP_Y          = 440,
   parameter int          SHIP_W          = 40,
   parameter int          SHIP_H          = 20,
   parameter int          SCREEN_BOTTOM   = 480,
   parameter int          TICK_LINE       = 480,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input logic         clk,
   input logic         reset,
   enemy_shot_if.slave bus
);
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [1:0] S_COOLDOWN = 2'd0;
   localparam logic [1:0] S_SEARCH   = 2'd1;
   localparam logic [1:0] S_FLIGHT   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [COL_W-1:0] srch_q, srch_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [9:0]       v1_q, v2_q;
   logic             active_q, active_d;
   logic [9:0]       posX_q, posX_d;
   logic [9:0]       posY_q, posY_d;
   logic             hit_q, hit_d;
   logic [7:0]       R_q, G_q, B_q;

   logic             tick;
   logic             col_found;
   logic [ROW_W-1:0] row_sel;
   logic [9:0]       spawn_x, spawn_y;
   logic [7:0]       speed;
   logic [10:0]      next_y;
   logic             hit_now, off_now, pix_on;

   assign tick = bus.enable && (v1_q == 10'(TICK_LINE)) && (v2_q != 10'(TICK_LINE));

   // Later rows overwrite earlier ones, so the lowest living invader wins.
   always_comb begin
      col_found = 1'b0;
      row_sel   = '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
         if (bus.alive_mask[r*COLS + 32'(col_q)]) begin
            col_found = 1'b1;
            row_sel   = ROW_W'(r);
         end
      end
   end

   assign spawn_x = 10'(32'(bus.grid_x0) + 32'(col_q)*COL_PITCH + ENEMY_W/2 - SHOT_W/2);
   assign spawn_y = 10'(32'(bus.grid_y0) + 32'(row_sel)*ROW_PITCH + ENEMY_H);

`ifdef ENEMY_SHOT_ACCEL_EN
   logic [7:0]  speed_q, speed_d;
   int unsigned dead;

   always_comb begin
      dead = 0;
      for (int unsigned i = 0; i < COLS*ROWS; i++)
         if (!bus.alive_mask[i]) dead++;
   end

   // Speed is latched at spawn so kills during flight do not change it.
   always_comb begin
      speed_d = speed_q;
      if (bus.enable && state_q == S_SEARCH && col_found)
         speed_d = 8'(SHOT_SPEED + (dead >> 3));
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) speed_q <= 8'(SHOT_SPEED);
      else       speed_q <= speed_d;

   assign speed = speed_q;
`else
   assign speed = 8'(SHOT_SPEED);
`endif

   assign next_y  = {1'b0, posY_q} + 11'(speed);
   assign hit_now = (32'(posX_q) < 32'(bus.posX_nave) + SHIP_W) &&
                    (32'(bus.posX_nave) < 32'(posX_q) + SHOT_W) &&
                    (32'(next_y) < SHIP_Y + SHIP_H) &&
                    (SHIP_Y < 32'(next_y) + SHOT_H);
   assign off_now = 32'(next_y) >= SCREEN_BOTTOM;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      col_d    = col_q;
      srch_d   = srch_q;
      active_d = active_q;
      posX_d   = posX_q;
      posY_d   = posY_q;
      hit_d    = 1'b0;
      lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (bus.enable) begin
         case (state_q)
            S_COOLDOWN: if (tick) begin
               if (cnt_q == '0) begin
                  col_d   = COL_W'(32'(lfsr_q[2:0]) % COLS);
                  srch_d  = '0;
                  state_d = S_SEARCH;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            S_SEARCH: begin
               if (col_found) begin
                  posX_d   = spawn_x;
                  posY_d   = spawn_y;
                  active_d = 1'b1;
                  state_d  = S_FLIGHT;
               end else if (32'(srch_q) == COLS-1) begin
                  cnt_d   = 16'(COOLDOWN_FRAMES);
                  state_d = S_COOLDOWN;
               end else begin
                  srch_d = srch_q + 1'b1;
                  col_d  = (32'(col_q) == COLS-1) ? '0 : col_q + 1'b1;
               end
            end
            S_FLIGHT: if (tick) begin
               if (hit_now || off_now) begin
                  hit_d    = hit_now;
                  active_d = 1'b0;
                  cnt_d    = 16'(COOLDOWN_FRAMES);
                  state_d  = S_COOLDOWN;
               end else begin
                  posY_d = next_y[9:0];
               end
            end
            default: state_d = S_COOLDOWN;
         endcase
      end
   end

   assign pix_on = active_q &&
                   (bus.h_counter >= posX_q) && (32'(bus.h_counter) < 32'(posX_q) + SHOT_W) &&
                   (bus.v_counter >= posY_q) && (32'(bus.v_counter) < 32'(posY_q) + SHOT_H);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_COOLDOWN;
         cnt_q    <= 16'(COOLDOWN_FRAMES);
         col_q    <= '0;
         srch_q   <= '0;
         lfsr_q   <= LFSR_SEED;
         v1_q     <= '0;
         v2_q     <= '0;
         active_q <= 1'b0;
         posX_q   <= '0;
         posY_q   <= '0;
         hit_q    <= 1'b0;
         R_q      <= '0;
         G_q      <= '0;
         B_q      <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         col_q    <= col_d;
         srch_q   <= srch_d;
         lfsr_q   <= lfsr_d;
         v1_q     <= bus.v_counter;
         v2_q     <= v1_q;
         active_q <= active_d;
         posX_q   <= posX_d;
         posY_q   <= posY_d;
         hit_q    <= hit_d;
         R_q      <= pix_on ? 8'hFF : 8'h00;
         G_q      <= pix_on ? 8'h40 : 8'h00;
         B_q      <= pix_on ? 8'h40 : 8'h00;
      end
   end

   assign bus.shot_active = active_q;
   assign bus.posX_shot   = posX_q;
   assign bus.posY_shot   = posY_q;
   assign bus.player_hit  = hit_q;
   assign bus.R           = R_q;
   assign bus.G           = G_q;
   assign bus.B           = B_q;
endmodule

// File: tb/tb_enemy_shot.sv
// Bench for enemy_shot: spawn table, flight/hit/off-screen sequences, pixel table.
module tb_enemy_shot;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   enemy_shot_if #(.COLS(8), .ROWS(3)) bus ();
   enemy_shot dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct { logic [23:0] mask; logic [9:0] gx, gy, ex, ey; } spawn_vec_t;
   typedef struct { logic [9:0] h, v; logic [23:0] rgb; } pix_vec_t;
   typedef struct { logic [9:0] x, y; } pos_t;

   pos_t        sb_pos[$];
   logic [23:0] sb_rgb[$];
   int checks = 0;
   int errors = 0;
   int hit_cnt = 0;
   int active_cycles = 0;

   always @(negedge clk) begin
      if (bus.player_hit)  hit_cnt++;
      if (bus.shot_active) active_cycles++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_tick();
      @(negedge clk) bus.v_counter = 10'd480;
      @(negedge clk) bus.v_counter = 10'd0;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) do_tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_spawn(input string name);
      pos_t p;
      for (int i = 0; i < 20 && !bus.shot_active; i++) @(negedge clk);
      chk({name, "_spawned"}, 32'(bus.shot_active), 32'd1);
      if (sb_pos.size() > 0) begin
         p = sb_pos.pop_front();
         chk({name, "_x"}, 32'(bus.posX_shot), 32'(p.x));
         chk({name, "_y"}, 32'(bus.posY_shot), 32'(p.y));
      end
   endtask

   spawn_vec_t sv[4];
   pix_vec_t   pv[7];

   initial begin
      int h0;
      logic [23:0] exp_rgb;
      sv[0] = '{24'h000400, 10'd100, 10'd40, 10'd278, 10'd120};
      sv[1] = '{24'h040404, 10'd100, 10'd40, 10'd278, 10'd170};
      sv[2] = '{24'h000020, 10'd0,   10'd0,  10'd418, 10'd30};
      sv[3] = '{24'h800000, 10'd10,  10'd20, 10'd588, 10'd150};
      pv[0] = '{10'd279, 10'd205, 24'hFF4040};
      pv[1] = '{10'd282, 10'd205, 24'h000000};
      pv[2] = '{10'd278, 10'd200, 24'hFF4040};
      pv[3] = '{10'd281, 10'd211, 24'hFF4040};
      pv[4] = '{10'd281, 10'd212, 24'h000000};
      pv[5] = '{10'd277, 10'd205, 24'h000000};
      pv[6] = '{10'd279, 10'd199, 24'h000000};

      bus.h_counter  = '0;
      bus.v_counter  = '0;
      bus.enable     = 1'b1;
      bus.alive_mask = 24'h000400;
      bus.grid_x0    = 10'd100;
      bus.grid_y0    = 10'd40;
      bus.posX_nave  = 10'd0;

      repeat (2) @(negedge clk);
      chk("rst_active", 32'(bus.shot_active), 0);
      chk("rst_hit",    32'(bus.player_hit), 0);
      chk("rst_rgb",    32'({bus.R, bus.G, bus.B}), 0);
      chk("rst_posx",   32'(bus.posX_shot), 0);
      chk("rst_posy",   32'(bus.posY_shot), 0);

      for (int i = 0; i < 4; i++) begin
         bus.alive_mask = sv[i].mask;
         bus.grid_x0    = sv[i].gx;
         bus.grid_y0    = sv[i].gy;
         do_reset();
         sb_pos.push_back('{sv[i].ex, sv[i].ey});
         ticks(30);
         chk($sformatf("vec%0d_no_early", i), 32'(bus.shot_active), 0);
         do_tick();
         wait_spawn($sformatf("vec%0d", i));
         if (i == 0) begin
            for (int k = 1; k <= 3; k++) begin
               do_tick();
               chk($sformatf("move%0d_y", k), 32'(bus.posY_shot), 32'(120 + 4*k));
            end
         end
      end

      // Ship under the shot: hit on the tick whose next_y is 432.
      bus.alive_mask = 24'h000400;
      bus.grid_x0    = 10'd100;
      bus.grid_y0    = 10'd40;
      bus.posX_nave  = 10'd258;
      do_reset();
      sb_pos.push_back('{10'd278, 10'd120});
      ticks(31);
      wait_spawn("hit_spawn");
      ticks(77);
      chk("hit_pre_y", 32'(bus.posY_shot), 32'd428);
      chk("hit_pre_active", 32'(bus.shot_active), 1);
      h0 = hit_cnt;
      do_tick();
      chk("hit_active_drop", 32'(bus.shot_active), 0);
      chk("hit_pulse", 32'(bus.player_hit), 1);
      @(negedge clk);
      chk("hit_pulse_end", 32'(bus.player_hit), 0);
      chk("hit_pulse_len", 32'(hit_cnt - h0), 1);
      sb_pos.push_back('{10'd278, 10'd120});
      ticks(30);
      chk("rearm_no_early", 32'(bus.shot_active), 0);
      do_tick();
      wait_spawn("rearm");

      // Ship out of the way: shot retires at the bottom.
      bus.posX_nave = 10'd0;
      do_reset();
      sb_pos.push_back('{10'd278, 10'd120});
      ticks(31);
      wait_spawn("off_spawn");
      ticks(89);
      chk("off_pre_y", 32'(bus.posY_shot), 32'd476);
      h0 = hit_cnt;
      do_tick();
      chk("off_active_drop", 32'(bus.shot_active), 0);
      @(negedge clk);
      chk("off_no_hit", 32'(hit_cnt - h0), 0);

      bus.alive_mask = 24'h000000;
      do_reset();
      h0 = active_cycles;
      ticks(100);
      chk("empty_never_fires", 32'(active_cycles - h0), 0);

      // Pixel output with the shot parked at (278,200).
      bus.alive_mask = 24'h000400;
      do_reset();
      sb_pos.push_back('{10'd278, 10'd120});
      ticks(31);
      wait_spawn("pix_spawn");
      ticks(20);
      chk("pix_pos_y", 32'(bus.posY_shot), 32'd200);
      bus.enable = 1'b0;
      ticks(3);
      chk("freeze_y", 32'(bus.posY_shot), 32'd200);
      chk("freeze_active", 32'(bus.shot_active), 1);
      bus.enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         bus.h_counter = pv[i].h;
         bus.v_counter = pv[i].v;
         sb_rgb.push_back(pv[i].rgb);
         @(negedge clk);
         exp_rgb = sb_rgb.pop_front();
         chk($sformatf("pix%0d_rgb", i), 32'({bus.R, bus.G, bus.B}), 32'(exp_rgb));
      end

      bus.h_counter = 10'd279;
      bus.v_counter = 10'd205;
      repeat (2) @(negedge clk);
      chk("pre_rst_rgb", 32'({bus.R, bus.G, bus.B}), 32'h00FF4040);
      h0 = hit_cnt;
      #2 reset = 1'b1;
      #1;
      chk("async_rst_rgb", 32'({bus.R, bus.G, bus.B}), 0);
      chk("async_rst_active", 32'(bus.shot_active), 0);
      chk("async_rst_posy", 32'(bus.posY_shot), 0);
      repeat (2) @(negedge clk);
      chk("async_rst_no_hit", 32'(hit_cnt - h0), 0);
      reset = 1'b0;
      bus.h_counter = '0;
      bus.v_counter = '0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
